// File: rtl/pe_event_fifo.sv
// pe_event_fifo: queues priority-encoder code changes in a FWFT FIFO.
// Optional drop counter enabled by defining PE_EVENT_FIFO_DROPCNT_EN.
module pe_event_fifo #(
  parameter int DEPTH     = 4,
  parameter int PUSH_IDLE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               code_in,
  output logic [7:0]               out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
`ifdef PE_EVENT_FIFO_DROPCNT_EN
  output logic [7:0]               drop_cnt,
`endif
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_prev;
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [7:0]  r_mem [DEPTH];
  logic        r_ovf;

  logic w_evt;
  logic w_push_req;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Change detection, handshake and FIFO status decode
  always_comb begin
    w_evt      = en && (code_in != r_prev);
    w_push_req = w_evt && ((code_in != 8'hF0) || (PUSH_IDLE == 1));
    w_empty    = (r_wr == r_rd);
    w_full     = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
    w_pop      = !w_empty && out_ready;
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
  end

  // Last seen code; follows every event, queued or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_prev <= 8'hF0;
    else if (w_evt)
      r_prev <= code_in;
  end

  // Read/write pointers with wrap bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[AW-1:0]] <= code_in;
  end

  // Sticky overflow; a drop wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (clr_ovf)
      r_ovf <= 1'b0;
  end

`ifdef PE_EVENT_FIFO_DROPCNT_EN
  logic [7:0] r_dcnt;

  // Saturating drop counter; drop with clear restarts at one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_dcnt <= 8'h00;
    else if (w_drop)
      r_dcnt <= clr_ovf ? 8'h01 :
                (r_dcnt == 8'hFF) ? 8'hFF : r_dcnt + 8'h01;
    else if (clr_ovf)
      r_dcnt <= 8'h00;
  end

  assign drop_cnt = r_dcnt;
`endif

  // First-word fall-through head; zero while empty
  always_comb begin
    out_valid = !w_empty;
    out_code  = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
    level     = r_wr - r_rd;
    overflow  = r_ovf;
  end

endmodule

// File: tb/tb_pe_event_fifo.sv
// tb_pe_event_fifo: directed table, corner sequences and random run
// against a queue-based reference model for PUSH_IDLE = 0 and 1.
module tb_pe_event_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    code_in;
  logic          out_ready;
  logic          clr_ovf;

  logic [7:0]    oc0, oc1;
  logic          ov0, ov1;
  logic [LW-1:0] lv0, lv1;
  logic          of0, of1;
`ifdef PE_EVENT_FIFO_DROPCNT_EN
  logic [7:0]    dc0, dc1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_event_fifo #(.DEPTH(DEPTH), .PUSH_IDLE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in),
    .out_code(oc0), .out_valid(ov0), .out_ready(out_ready),
    .level(lv0), .overflow(of0),
`ifdef PE_EVENT_FIFO_DROPCNT_EN
    .drop_cnt(dc0),
`endif
    .clr_ovf(clr_ovf)
  );

  pe_event_fifo #(.DEPTH(DEPTH), .PUSH_IDLE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in),
    .out_code(oc1), .out_valid(ov1), .out_ready(out_ready),
    .level(lv1), .overflow(of1),
`ifdef PE_EVENT_FIFO_DROPCNT_EN
    .drop_cnt(dc1),
`endif
    .clr_ovf(clr_ovf)
  );

  // reference model: one code queue per instance
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] mprev[2];
  bit         movf[2];
  int         mdc[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int p = 0; p < 2; p++) begin
      mprev[p] = 8'hF0;
      movf[p]  = 1'b0;
      mdc[p]   = 0;
    end
  endtask

  task automatic model_step(input int p, input bit e, input logic [7:0] c,
                            input bit r, input bit cl);
    logic [7:0] q[$];
    bit evt, preq, drop;
    if (p == 0) q = mq0; else q = mq1;
    evt  = e && (c != mprev[p]);
    preq = evt && ((c != 8'hF0) || (p == 1));
    drop = 1'b0;
    if (r && q.size() > 0) void'(q.pop_front());
    if (preq) begin
      if (q.size() < DEPTH) q.push_back(c);
      else drop = 1'b1;
    end
    if (drop) begin
      movf[p] = 1'b1;
      mdc[p]  = cl ? 1 : (mdc[p] < 255 ? mdc[p] + 1 : 255);
    end else if (cl) begin
      movf[p] = 1'b0;
      mdc[p]  = 0;
    end
    if (evt) mprev[p] = c;
    if (p == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic check_all();
    chk("m0_valid", ov0, mq0.size() > 0);
    chk("m0_code", oc0, mq0.size() > 0 ? mq0[0] : 8'h00);
    chk("m0_level", lv0, mq0.size());
    chk("m0_ovf", of0, movf[0]);
    chk("m1_valid", ov1, mq1.size() > 0);
    chk("m1_code", oc1, mq1.size() > 0 ? mq1[0] : 8'h00);
    chk("m1_level", lv1, mq1.size());
    chk("m1_ovf", of1, movf[1]);
`ifdef PE_EVENT_FIFO_DROPCNT_EN
    chk("m0_dcnt", dc0, mdc[0]);
    chk("m1_dcnt", dc1, mdc[1]);
`endif
  endtask

  task automatic cycle(input bit e, input logic [7:0] c, input bit r,
                       input bit cl);
    @(negedge clk);
    en = e; code_in = c; out_ready = r; clr_ovf = cl;
    @(posedge clk);
    model_step(0, e, c, r, cl);
    model_step(1, e, c, r, cl);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; code_in = 8'hF0; out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         e;
    logic [7:0] c;
    bit         r;
    bit         cl;
    bit         xv;
    logic [7:0] xc;
    int         xl;
    bit         xo;
    int         xd;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{1, 8'h0B, 0, 0, 1, 8'h0B, 1, 0, 0};
    tbl[2]  = '{1, 8'h0B, 0, 0, 1, 8'h0B, 1, 0, 0};
    tbl[3]  = '{0, 8'h05, 0, 0, 1, 8'h0B, 1, 0, 0};
    tbl[4]  = '{1, 8'h0B, 1, 0, 0, 8'h00, 0, 0, 0};
    tbl[5]  = '{1, 8'h01, 0, 0, 1, 8'h01, 1, 0, 0};
    tbl[6]  = '{1, 8'h02, 0, 0, 1, 8'h01, 2, 0, 0};
    tbl[7]  = '{1, 8'h03, 0, 0, 1, 8'h01, 3, 0, 0};
    tbl[8]  = '{1, 8'h04, 0, 0, 1, 8'h01, 4, 0, 0};
    tbl[9]  = '{1, 8'h05, 0, 0, 1, 8'h01, 4, 1, 1};
    tbl[10] = '{1, 8'h05, 0, 1, 1, 8'h01, 4, 0, 0};
    tbl[11] = '{1, 8'h09, 1, 0, 1, 8'h02, 4, 0, 0};
    tbl[12] = '{1, 8'h0A, 0, 1, 1, 8'h02, 4, 1, 1};
    tbl[13] = '{1, 8'h0A, 0, 1, 1, 8'h02, 4, 0, 0};
    tbl[14] = '{1, 8'h0A, 1, 0, 1, 8'h03, 3, 0, 0};
    tbl[15] = '{1, 8'h0A, 1, 0, 1, 8'h04, 2, 0, 0};
    tbl[16] = '{1, 8'h0A, 1, 0, 1, 8'h09, 1, 0, 0};
    tbl[17] = '{1, 8'h0A, 1, 0, 0, 8'h00, 0, 0, 0};
    tbl[18] = '{1, 8'h0A, 1, 0, 0, 8'h00, 0, 0, 0};

    rst = 1'b1; en = 1'b0; code_in = 8'hF0; out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", ov0, 0);
    chk("rst_level", lv0, 0);
    chk("rst_ovf", of0, 0);
    chk("rst_code", oc0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) cycle(1, 8'hF0, 0, 0);
    chk("idle_valid", ov0, 0);
    chk("idle_level", lv0, 0);

    // directed table: single event, fill, drop, full push+pop, clear
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].e, tbl[i].c, tbl[i].r, tbl[i].cl);
      chk($sformatf("tbl%0d_valid", i), ov0, tbl[i].xv);
      chk($sformatf("tbl%0d_code", i), oc0, tbl[i].xc);
      chk($sformatf("tbl%0d_level", i), lv0, tbl[i].xl);
      chk($sformatf("tbl%0d_ovf", i), of0, tbl[i].xo);
`ifdef PE_EVENT_FIFO_DROPCNT_EN
      chk($sformatf("tbl%0d_dcnt", i), dc0, tbl[i].xd);
`endif
    end

    // idle code handling for both PUSH_IDLE settings
    do_reset();
    cycle(1, 8'h03, 0, 0);
    cycle(1, 8'hF0, 0, 0);
    cycle(1, 8'h03, 0, 0);
    chk("idle0_level", lv0, 2);
    chk("idle1_level", lv1, 3);
    chk("idle0_h0", oc0, 8'h03);
    chk("idle1_h0", oc1, 8'h03);
    cycle(1, 8'h03, 1, 0);
    chk("idle0_h1", oc0, 8'h03);
    chk("idle1_h1", oc1, 8'hF0);
    cycle(1, 8'h03, 1, 0);
    chk("idle0_empty", ov0, 0);
    chk("idle1_h2", oc1, 8'h03);
    cycle(1, 8'h03, 1, 0);
    chk("idle1_empty", ov1, 0);

    // pointer wrap with streaming push/pop
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] c;
      c = 8'((i % 8) + 1);
      cycle(1, c, 1, 0);
      chk($sformatf("wrap%0d_code", i), oc0, c);
      chk($sformatf("wrap%0d_level", i), lv0, 1);
    end

    // asynchronous reset with three queued entries
    do_reset();
    cycle(1, 8'h01, 0, 0);
    cycle(1, 8'h02, 0, 0);
    cycle(1, 8'h03, 0, 0);
    chk("arst_pre_level", lv0, 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    code_in = 8'h07;
    model_reset();
    #1;
    chk("arst_valid0", ov0, 0);
    chk("arst_level0", lv0, 0);
    chk("arst_level1", lv1, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 8'h07, 0, 0);
    chk("arst_post_level", lv0, 1);
    chk("arst_post_code", oc0, 8'h07);

    // many drops: overflow stays set, counter saturates
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, (i % 2) ? 8'h05 : 8'h06, 0, 0);
    chk("sat_ovf", of0, 1);
    chk("sat_level", lv0, 4);
`ifdef PE_EVENT_FIFO_DROPCNT_EN
    chk("sat_dcnt", dc0, 8'hFF);
`endif
    cycle(1, 8'h05, 0, 1);
    chk("sat_clr_ovf", of0, 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [7:0] c;
      int k;
      k = $urandom_range(0, 17);
      c = (k >= 16) ? 8'hF0 : 8'(k);
      cycle($urandom_range(0, 7) != 0, c, $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
